// File: rtl/alu_pkg.sv
// alu_pkg: op codes and FSM state encodings shared by alu_md, md_iter and the bench.
package alu_pkg;
  typedef enum logic [2:0] {
    OP_ADDU  = 3'b000,
    OP_SUBU  = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_MULTU = 3'b100,
    OP_DIVU  = 3'b101,
    OP_MULT  = 3'b110,
    OP_DIV   = 3'b111
  } op_e;
  // Legacy decoder names; must track OP_ADDU/OP_SUBU.
  localparam logic [2:0] ALUOp_ADDU = 3'b000;
  localparam logic [2:0] ALUOp_SUBU = 3'b001;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_e;
endpackage

// File: rtl/md_iter.sv
// md_iter: one-bit-per-cycle shift-add multiply / restoring divide on unsigned magnitudes.
// p holds {acc/remainder, multiplier/quotient}; p_next is the value after the current step.
module md_iter #(parameter int WIDTH = 32) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               load,
  input  logic               step,
  input  logic               div,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   m_in,
  output logic [2*WIDTH-1:0] p_next
);
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH:0] sum, rem_sh;
  logic ge;
  always_comb begin
    sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_in} : {(WIDTH+1){1'b0}});
    rem_sh = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    ge     = rem_sh >= {1'b0, m_in};
    p_next = div ? {ge ? WIDTH'(rem_sh - {1'b0, m_in}) : rem_sh[WIDTH-1:0], p_q[WIDTH-2:0], ge}
                 : {sum, p_q[WIDTH-1:1]};
    p_d    = load ? {{WIDTH{1'b0}}, a_in} : step ? p_next : p_q;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) p_q <= '0;
    else       p_q <= p_d;
endmodule

// File: rtl/alu_md.sv
// alu_md: single-cycle ADDU/SUBU/AND/OR plus iterative MULTU/DIVU (done WIDTH+1 cycles after start).
// Define SIGNED_MD_EN for two's-complement MULT/DIV; otherwise ops 110/111 alias 100/101.
module alu_md
  import alu_pkg::*;
#(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic div_q, div_d, sc_done_q, sc_done_d, accept, last;
  logic [WIDTH-1:0] m_q, m_d, result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] alu_res, a_mag, b_mag;
  logic [2*WIDTH-1:0] p_next, md_res;

  assign accept  = start && state_q != RUN;
  assign last    = state_q == RUN && cnt_q == CW'(WIDTH-1);
  assign alu_res = op[1] ? (op[0] ? a | b : a & b) : (op[0] ? a - b : a + b);

`ifdef SIGNED_MD_EN
  // Engine runs on magnitudes; signs are captured at launch and applied to the final step.
  logic sgn, qneg_q, qneg_d, rneg_q, rneg_d;
  assign sgn    = op[2] & op[1];
  assign a_mag  = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (sgn && b[WIDTH-1]) ? -b : b;
  assign qneg_d = (accept && op[2]) ? sgn && (a[WIDTH-1] ^ b[WIDTH-1]) : qneg_q;
  assign rneg_d = (accept && op[2]) ? sgn && a[WIDTH-1] : rneg_q;
  assign md_res = div_q ? {rneg_q ? -p_next[2*WIDTH-1:WIDTH] : p_next[2*WIDTH-1:WIDTH],
                           qneg_q ? -p_next[WIDTH-1:0] : p_next[WIDTH-1:0]}
                        : (qneg_q ? -p_next : p_next);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign md_res = p_next;
`endif

  md_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rstn   (rstn),
    .load   (accept && op[2]),
    .step   (state_q == RUN),
    .div    (div_q),
    .a_in   (a_mag),
    .m_in   (m_q),
    .p_next (p_next)
  );

  always_comb begin
    state_d   = (state_q == FIN) ? IDLE : state_q;
    cnt_d     = cnt_q + 1'b1;
    div_d     = div_q;
    m_d       = m_q;
    result_d  = (accept && !op[2]) ? alu_res : result_q;
    sc_done_d = accept && !op[2];
    {hi_d, lo_d} = last ? md_res : {hi_q, lo_q};
    if (accept && op[2]) begin
      state_d = RUN;
      cnt_d   = '0;
      div_d   = op[0];
      m_d     = b_mag;
    end
    if (last) state_d = FIN;
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      m_q       <= '0;
      result_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      sc_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      m_q       <= m_d;
      result_q  <= result_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      sc_done_q <= sc_done_d;
    end

  assign result = result_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign busy   = state_q == RUN;
  assign done   = state_q == FIN || sc_done_q;
  assign zero   = a == b;
endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: table-driven directed vectors plus hand sequences for busy-ignore, FIN restart and mid-run reset.
// Latency counts clock edges from the edge sampling start (=1) to the cycle where done is seen high.
module tb_alu_md;
  import alu_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [2:0] op = 3'b000;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] result, hi, lo;
  logic busy, done, zero;
  int checks = 0, errors = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, x, y;
  } vec_t;
  vec_t vt[14];

  alu_md #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b),
    .result(result), .hi(hi), .lo(lo), .busy(busy), .done(done), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is first seen (or after a bound).
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int inj, output int lat, output logic bsy);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; bsy = busy; lat = 1;
    while (!done && lat < 200) begin
      if (lat == inj) begin start = 1'b1; op = OP_SUBU; a = 32'd9; b = 32'd1; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, n;
    logic bsy;
    logic [W-1:0] mres, mhi, mlo;
    vt[0]  = '{OP_ADDU,  32'hFFFFFFFF, 32'h2,        32'h00000001, 32'h0};
    vt[1]  = '{OP_ADDU,  32'h7FFFFFFF, 32'h1,        32'h80000000, 32'h0};
    vt[2]  = '{OP_SUBU,  32'h5,        32'h7,        32'hFFFFFFFE, 32'h0};
    vt[3]  = '{OP_AND,   32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 32'h0};
    vt[4]  = '{OP_OR,    32'hF0F0FF00, 32'h0FF0F0F0, 32'hFFF0FFF0, 32'h0};
    vt[5]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vt[6]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vt[7]  = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vt[8]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h1,        32'h0};
    vt[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF};
`ifdef SIGNED_MD_EN
    vt[10] = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
    vt[11] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[12] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000};
`else
    vt[10] = '{OP_MULT,  32'd3,        32'd5,        32'h0,        32'd15};
    vt[11] = '{OP_DIV,   32'd100,      32'd7,        32'd2,        32'd14};
    vt[12] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0};
`endif
    vt[13] = '{OP_SUBU,  32'h0,        32'h1,        32'hFFFFFFFF, 32'h0};
    mres = '0; mhi = '0; mlo = '0;

    repeat (2) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rstn = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      do_op(vt[i].op, vt[i].a, vt[i].b, 0, lat, bsy);
      if (vt[i].op[2]) begin mhi = vt[i].x; mlo = vt[i].y; end
      else mres = vt[i].x;
      chk($sformatf("v%0d_lat", i), 64'(lat), vt[i].op[2] ? 64'd33 : 64'd1);
      chk($sformatf("v%0d_busy", i), bsy, vt[i].op[2]);
      chk($sformatf("v%0d_result", i), result, mres);
      chk($sformatf("v%0d_hi", i), hi, mhi);
      chk($sformatf("v%0d_lo", i), lo, mlo);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done, 0);
    end

    // SUBU issued mid-MULTU with different operands must be ignored.
    @(negedge clk);
    do_op(OP_MULTU, 32'h00010001, 32'h00010001, 10, lat, bsy);
    chk("ign_lat", 64'(lat), 33);
    chk("ign_hi", hi, 32'h1);
    chk("ign_lo", lo, 32'h00020001);
    chk("ign_result", result, mres);

    // Starts accepted in the FIN cycle.
    @(negedge clk);
    do_op(OP_MULTU, 32'd3, 32'd4, 0, lat, bsy);
    do_op(OP_ADDU, 32'd1, 32'd1, 0, lat, bsy);
    chk("fin_sc_lat", 64'(lat), 1);
    chk("fin_sc_result", result, 32'd2);
    chk("fin_sc_lo", lo, 32'd12);
    @(negedge clk);
    do_op(OP_MULTU, 32'd5, 32'd5, 0, lat, bsy);
    do_op(OP_DIVU, 32'd9, 32'd2, 0, lat, bsy);
    chk("fin_it_lat", 64'(lat), 33);
    chk("fin_it_hi", hi, 32'd1);
    chk("fin_it_lo", lo, 32'd4);

    // Reset asserted mid-RUN.
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("mid_busy_before", busy, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_hi", hi, 0);
    chk("mid_rst_lo", lo, 0);
    @(negedge clk);
    rstn = 1'b1;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("mid_no_done", 64'(n), 0);
    do_op(OP_DIVU, 32'd9, 32'd3, 0, lat, bsy);
    chk("post_rst_lat", 64'(lat), 33);
    chk("post_rst_lo", lo, 32'd3);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_result", result, 0);

    a = 32'd42; b = 32'd42;
    #1 chk("zero_eq", zero, 1);
    b = 32'd43;
    #1 chk("zero_ne", zero, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
